// File: rtl/complx_operand_stage_if.sv
// ---------------------------------------------------------------------------
// complx_operand_stage_if
// Stream bundle between the operand memory read side, the operand stage and
// the butterfly input registers.
//
// Handshake: a beat moves across an edge exactly when valid && ready are both
// high at that edge. A producer holds its payload stable while valid is high
// and ready is low; valid never depends combinationally on ready.
//
// Signals (stage view):
//   mode_in          requested operand mode, sampled on first beat of a frame
//   s_valid/s_ready  input beat handshake, s_last marks end of frame
//   a/b_re/im_in     input operand fields (two's complement, WIDTH bits)
//   m_valid/m_ready  output beat handshake, m_last copies s_last
//   a/b_re/im_out    processed operand fields
//   idx_out          beat index within the frame (IDX_W bits, wraps)
//   sat_out          conjugate negation saturated on this beat
//   mode_active      mode locked for the currently open frame
// Modports: master = stream source / sink side, slave = the operand stage.
// ---------------------------------------------------------------------------
interface complx_operand_stage_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
);
  logic [1:0]       mode_in;
  logic             s_valid;
  logic             s_ready;
  logic             s_last;
  logic [WIDTH-1:0] a_re_in;
  logic [WIDTH-1:0] b_re_in;
  logic [WIDTH-1:0] a_im_in;
  logic [WIDTH-1:0] b_im_in;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [WIDTH-1:0] a_re_out;
  logic [WIDTH-1:0] b_re_out;
  logic [WIDTH-1:0] a_im_out;
  logic [WIDTH-1:0] b_im_out;
  logic [IDX_W-1:0] idx_out;
  logic             sat_out;
  logic [1:0]       mode_active;

  modport master (
    output mode_in, s_valid, s_last, a_re_in, b_re_in, a_im_in, b_im_in,
           m_ready,
    input  s_ready, m_valid, m_last, a_re_out, b_re_out, a_im_out, b_im_out,
           idx_out, sat_out, mode_active
  );

  modport slave (
    input  mode_in, s_valid, s_last, a_re_in, b_re_in, a_im_in, b_im_in,
           m_ready,
    output s_ready, m_valid, m_last, a_re_out, b_re_out, a_im_out, b_im_out,
           idx_out, sat_out, mode_active
  );
endinterface

// File: rtl/complx_operand_stage.sv
// ---------------------------------------------------------------------------
// complx_operand_stage
// Registered operand stage in front of the butterfly. Each accepted beat is
// transformed according to the frame's operand mode (0 real-dup, 1 complex,
// 2 conjugate with saturation, 3 real with zero imaginary), tagged with a
// per-frame beat index and presented through an OUT + SKID two-entry buffer.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    complx_operand_stage_if.slave (input stream, output stream,
//          mode request and locked mode)
//
// s_ready is a pure register output (!skid_valid), so there is no
// combinational path from m_ready to s_ready.
// ---------------------------------------------------------------------------
module complx_operand_stage #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  complx_operand_stage_if.slave bus
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] a_re;
    logic [WIDTH-1:0] b_re;
    logic [WIDTH-1:0] a_im;
    logic [WIDTH-1:0] b_im;
    logic [IDX_W-1:0] idx;
    logic             sat;
  } beat_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  // Saturating negation: returns {saturated, value}. Only the most negative
  // value lacks a positive counterpart and clamps to the maximum.
  function automatic logic [WIDTH:0] sat_neg(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = WIDTH'(0) - x;
    if (x == MIN_VAL) return {1'b1, MAX_VAL};
    else              return {1'b0, n};
  endfunction

  // Frame tracking state
  logic             frame_open_q, frame_open_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       mode_active_q, mode_active_d;

  // Output buffer state
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  beat_t            out_q, out_d;
  beat_t            skid_q, skid_d;

  logic             accept;
  logic [1:0]       mode_use;
  logic [WIDTH:0]   neg_a, neg_b;
  beat_t            beat_new;

  assign accept = bus.s_valid && !skid_valid_q;

  // Transform of the beat currently offered on the input. The first beat of
  // a frame uses mode_in directly since mode_active only updates afterwards.
  always_comb begin
    beat_new = '0;
    mode_use = frame_open_q ? mode_active_q : bus.mode_in;
    neg_a    = sat_neg(bus.a_im_in);
    neg_b    = sat_neg(bus.b_im_in);
    beat_new.last = bus.s_last;
    beat_new.a_re = bus.a_re_in;
    beat_new.b_re = bus.b_re_in;
    beat_new.idx  = idx_q;
    case (mode_use)
      2'd0: begin
        beat_new.a_im = bus.a_re_in;
        beat_new.b_im = bus.b_re_in;
      end
      2'd1: begin
        beat_new.a_im = bus.a_im_in;
        beat_new.b_im = bus.b_im_in;
      end
      2'd2: begin
        beat_new.a_im = neg_a[WIDTH-1:0];
        beat_new.b_im = neg_b[WIDTH-1:0];
        beat_new.sat  = neg_a[WIDTH] | neg_b[WIDTH];
      end
      default: begin
        beat_new.a_im = '0;
        beat_new.b_im = '0;
      end
    endcase
  end

  // Frame / index / locked-mode next state. idx_q is already 0 whenever the
  // frame is closed, so it is used directly as the beat's index.
  always_comb begin
    frame_open_d  = frame_open_q;
    idx_d         = idx_q;
    mode_active_d = mode_active_q;
    if (accept) begin
      if (!frame_open_q) mode_active_d = bus.mode_in;
      frame_open_d = !bus.s_last;
      idx_d        = bus.s_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Buffer next state. accept implies SKID is empty, so a SKID->OUT move
  // never coincides with a new beat needing a slot.
  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (!out_valid_q || bus.m_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = beat_new;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = beat_new;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_open_q  <= 1'b0;
      idx_q         <= '0;
      mode_active_q <= 2'd0;
      out_valid_q   <= 1'b0;
      skid_valid_q  <= 1'b0;
      out_q         <= '0;
      skid_q        <= '0;
    end else begin
      frame_open_q  <= frame_open_d;
      idx_q         <= idx_d;
      mode_active_q <= mode_active_d;
      out_valid_q   <= out_valid_d;
      skid_valid_q  <= skid_valid_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
    end
  end

  assign bus.s_ready     = !skid_valid_q;
  assign bus.m_valid     = out_valid_q;
  assign bus.m_last      = out_q.last;
  assign bus.a_re_out    = out_q.a_re;
  assign bus.b_re_out    = out_q.b_re;
  assign bus.a_im_out    = out_q.a_im;
  assign bus.b_im_out    = out_q.b_im;
  assign bus.idx_out     = out_q.idx;
  assign bus.sat_out     = out_q.sat;
  assign bus.mode_active = mode_active_q;

endmodule

// File: tb/tb_complx_operand_stage.sv
module tb_complx_operand_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  complx_operand_stage_if #(.WIDTH(16), .IDX_W(8)) bus ();
  complx_operand_stage_if #(.WIDTH(16), .IDX_W(2)) bus2 ();

  complx_operand_stage #(.WIDTH(16), .IDX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  complx_operand_stage #(.WIDTH(16), .IDX_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] mode, input logic [15:0] are, input logic [15:0] bre,
                          input logic [15:0] aim, input logic [15:0] bim, input logic last);
    bus.s_valid = 1'b1;
    bus.mode_in = mode;
    bus.a_re_in = are;
    bus.b_re_in = bre;
    bus.a_im_in = aim;
    bus.b_im_in = bim;
    bus.s_last  = last;
  endtask

  logic [15:0] k;
  int          acc_n;
  logic        acc;
  logic [1:0]  exp_idx2 [6];

  initial begin
    checks = 0;
    errors = 0;
    exp_idx2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.mode_in = 2'd0; bus.m_ready = 1'b0;
    bus.a_re_in = '0; bus.b_re_in = '0; bus.a_im_in = '0; bus.b_im_in = '0;
    bus2.s_valid = 1'b0; bus2.s_last = 1'b0; bus2.mode_in = 2'd0; bus2.m_ready = 1'b1;
    bus2.a_re_in = '0; bus2.b_re_in = '0; bus2.a_im_in = '0; bus2.b_im_in = '0;
    tick();
    tick();

    // Reset state
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_mode_active", 32'(bus.mode_active), 32'd0);
    check("rst_a_re_out", 32'(bus.a_re_out), 32'd0);
    check("rst_idx", 32'(bus.idx_out), 32'd0);
    check("rst_sat", 32'(bus.sat_out), 32'd0);
    check("rst_m_last", 32'(bus.m_last), 32'd0);

    rst_n = 1'b1;
    tick();

    // Mode 0 single-beat frame, one-cycle latency
    bus.m_ready = 1'b1;
    set_beat(2'd0, 16'h1234, 16'hFFFE, 16'h7777, 16'h5555, 1'b1);
    tick();
    check("m0_valid", 32'(bus.m_valid), 32'd1);
    check("m0_a_re", 32'(bus.a_re_out), 32'h1234);
    check("m0_b_re", 32'(bus.b_re_out), 32'hFFFE);
    check("m0_a_im", 32'(bus.a_im_out), 32'h1234);
    check("m0_b_im", 32'(bus.b_im_out), 32'hFFFE);
    check("m0_idx", 32'(bus.idx_out), 32'd0);
    check("m0_last", 32'(bus.m_last), 32'd1);
    check("m0_sat", 32'(bus.sat_out), 32'd0);

    // Mode 2 with saturation, then without
    set_beat(2'd2, 16'h0100, 16'h0200, 16'h8000, 16'h0003, 1'b1);
    tick();
    check("m2s_a_re", 32'(bus.a_re_out), 32'h0100);
    check("m2s_a_im", 32'(bus.a_im_out), 32'h7FFF);
    check("m2s_b_im", 32'(bus.b_im_out), 32'hFFFD);
    check("m2s_sat", 32'(bus.sat_out), 32'd1);
    check("m2s_mode_active", 32'(bus.mode_active), 32'd2);
    check("m2s_idx", 32'(bus.idx_out), 32'd0);
    set_beat(2'd2, 16'h0101, 16'h0201, 16'h0001, 16'h0002, 1'b1);
    tick();
    check("m2_a_im", 32'(bus.a_im_out), 32'hFFFF);
    check("m2_b_im", 32'(bus.b_im_out), 32'hFFFE);
    check("m2_sat", 32'(bus.sat_out), 32'd0);
    bus.s_valid = 1'b0;
    tick();
    check("drain_m_valid", 32'(bus.m_valid), 32'd0);

    // 4-beat mode 1 frame, mode_in switched to 3 mid-frame
    for (int i = 0; i < 4; i++) begin
      set_beat((i < 2) ? 2'd1 : 2'd3, 16'(16'h0300 + i), 16'(16'h0400 + i),
               16'(16'h0100 + i), 16'(16'h0200 + i), (i == 3));
      tick();
      check("f1_a_im", 32'(bus.a_im_out), 32'(16'h0100 + i));
      check("f1_b_im", 32'(bus.b_im_out), 32'(16'h0200 + i));
      check("f1_idx", 32'(bus.idx_out), 32'(i));
      check("f1_last", 32'(bus.m_last), 32'(i == 3));
      check("f1_mode_active", 32'(bus.mode_active), 32'd1);
    end
    // Next frame picks up mode 3
    set_beat(2'd3, 16'h0500, 16'h0600, 16'h1111, 16'h2222, 1'b0);
    tick();
    check("f3_a_re", 32'(bus.a_re_out), 32'h0500);
    check("f3_a_im", 32'(bus.a_im_out), 32'h0000);
    check("f3_b_im", 32'(bus.b_im_out), 32'h0000);
    check("f3_idx", 32'(bus.idx_out), 32'd0);
    check("f3_mode_active", 32'(bus.mode_active), 32'd3);
    set_beat(2'd1, 16'h0501, 16'h0601, 16'h1112, 16'h2223, 1'b1);
    tick();
    check("f3b_a_im", 32'(bus.a_im_out), 32'h0000);
    check("f3b_idx", 32'(bus.idx_out), 32'd1);
    check("f3b_last", 32'(bus.m_last), 32'd1);
    bus.s_valid = 1'b0;
    tick();
    check("f3_drain", 32'(bus.m_valid), 32'd0);

    // Backpressure: m_ready low 5 cycles, s_valid held high
    bus.m_ready = 1'b0;
    k = 16'h0A00;
    set_beat(2'd1, k, 16'h0B00, 16'h0C00, 16'h0D00, 1'b0);
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      acc = bus.s_ready;
      tick();
      if (acc) begin
        acc_n++;
        k = k + 16'd1;
        bus.a_re_in = k;
      end
      if (c == 1) check("bp_s_ready_fall", 32'(bus.s_ready), 32'd0);
    end
    check("bp_accepted", 32'(acc_n), 32'd2);
    check("bp_s_ready", 32'(bus.s_ready), 32'd0);
    check("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check("bp_hold_a_re", 32'(bus.a_re_out), 32'h0A00);
    check("bp_hold_idx", 32'(bus.idx_out), 32'd0);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    check("bp_skid_a_re", 32'(bus.a_re_out), 32'h0A01);
    check("bp_skid_idx", 32'(bus.idx_out), 32'd1);
    check("bp_skid_valid", 32'(bus.m_valid), 32'd1);
    check("bp_s_ready_back", 32'(bus.s_ready), 32'd1);
    tick();
    check("bp_empty", 32'(bus.m_valid), 32'd0);
    set_beat(2'd0, 16'h0A02, 16'h0B00, 16'h0C00, 16'h0D00, 1'b1);
    tick();
    check("bp_close_idx", 32'(bus.idx_out), 32'd2);
    check("bp_close_a_im", 32'(bus.a_im_out), 32'h0C00);
    check("bp_close_last", 32'(bus.m_last), 32'd1);
    bus.s_valid = 1'b0;
    tick();

    // Narrow index: IDX_W=2, 6-beat frame, mode_in changed after wrap
    bus2.s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus2.s_last  = (i == 5);
      bus2.mode_in = (i >= 4) ? 2'd3 : 2'd1;
      bus2.a_im_in = 16'(i + 1);
      tick();
      check("w_idx", 32'(bus2.idx_out), 32'(exp_idx2[i]));
      check("w_a_im", 32'(bus2.a_im_out), 32'(i + 1));
      check("w_last", 32'(bus2.m_last), 32'(i == 5));
      check("w_mode_active", 32'(bus2.mode_active), 32'd1);
    end
    bus2.s_valid = 1'b0;
    bus2.s_last  = 1'b0;
    tick();

    // Reset mid-frame with OUT and SKID full
    bus.m_ready = 1'b0;
    set_beat(2'd2, 16'h0E00, 16'h0E01, 16'h0005, 16'h0006, 1'b0);
    tick();
    tick();
    check("mr_full_s_ready", 32'(bus.s_ready), 32'd0);
    check("mr_full_m_valid", 32'(bus.m_valid), 32'd1);
    check("mr_full_mode", 32'(bus.mode_active), 32'd2);
    rst_n = 1'b0;
    tick();
    check("mr_m_valid", 32'(bus.m_valid), 32'd0);
    check("mr_s_ready", 32'(bus.s_ready), 32'd1);
    check("mr_mode_active", 32'(bus.mode_active), 32'd0);
    check("mr_a_re", 32'(bus.a_re_out), 32'd0);
    check("mr_a_im", 32'(bus.a_im_out), 32'd0);
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    set_beat(2'd3, 16'h0C00, 16'h0C01, 16'h1234, 16'h4321, 1'b1);
    tick();
    check("mr_next_valid", 32'(bus.m_valid), 32'd1);
    check("mr_next_idx", 32'(bus.idx_out), 32'd0);
    check("mr_next_a_re", 32'(bus.a_re_out), 32'h0C00);
    check("mr_next_a_im", 32'(bus.a_im_out), 32'h0000);
    check("mr_next_mode", 32'(bus.mode_active), 32'd3);
    bus.s_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
